decay_timestep_scheduler: RTL and testbench

Timestep controller for the LIF potential decay datapath of the neuron accelerator. On each timestep pulse it walks every neuron slot in the potential RAM once: read, apply that neuron's decay rate (exponent shift, or /2 + /4 via the shared FP adder), write back. It replaces the free-running set/clear strobing of per-neuron decay units with one sequenced, time-shared unit and reports completion to the timestep controller.

---
 rtl/decay_timestep_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_decay_timestep_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decay_timestep_scheduler.sv
// ============================================================================
// decay_timestep_scheduler
// Sequences one LIF potential decay pass over the potential RAM per timestep
// pulse: read, apply the per-neuron decay rate, write back, report done.
// The rate table and the read/calc/write sequencing are always present.
// Optional feature macro: DECAY_ADD_EN. When defined, rate code 0011
// (x/2 + x/4) goes through the shared FP adder handshake. When not defined,
// the adder ports are tied off and rate code 0011 behaves as /1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decay_timestep_scheduler #(
  parameter int NUM_NEURONS = 30,
  parameter int ADDR_W      = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              timestep_start,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_rate,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              add_req,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic              add_ack,
  input  logic [31:0]       add_result,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [3:0]      RATE_ADD = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WAIT     = 3'd2,
    S_CALC     = 3'd3,
    S_WRITE    = 3'd4,
    S_FIN      = 3'd5
`ifdef DECAY_ADD_EN
    , S_ADD_WAIT = 3'd6
`endif
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   idx;
  logic [3:0]          rate;
  logic [31:0]         x;
  logic [31:0]         result;
  logic                overrun_q;
  logic [3:0]          rate_tab [DEPTH];

  // Exponent-only divide by 2^k; Inf/NaN and zero/denormal pass through,
  // exponent underflow flushes to a zero of the same sign.
  function automatic logic [31:0] decay_shift(input logic [31:0] v, input logic [1:0] k);
    logic [7:0] e;
    e = v[30:23];
    if (e == 8'hFF || e == 8'h00)
      return v;
    else if (e <= {6'b0, k})
      return {v[31], 31'b0};
    else
      return {v[31], e - {6'b0, k}, v[22:0]};
  endfunction

  // Rate code to shift amount; unlisted codes (including 0011) mean /1.
  function automatic logic [1:0] rate_shift(input logic [3:0] r);
    case (r)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign mem_addr  = idx;
  assign mem_wdata = result;
  assign overrun   = overrun_q;

  // Decay rate table, writable at any time; each pass latches an entry in READ.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) rate_tab[i] <= 4'b0001;
    end else if (cfg_we) begin
      rate_tab[cfg_addr] <= cfg_rate;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state decode and strobes, all derived from the current state.
  always_comb begin
    state_n = state;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    add_req = 1'b0;
    case (state)
      S_IDLE:  if (timestep_start) state_n = S_READ;
      S_READ:  begin busy = 1'b1; mem_re = 1'b1; state_n = S_WAIT; end
      S_WAIT:  begin busy = 1'b1; state_n = S_CALC; end
      S_CALC: begin
        busy    = 1'b1;
        state_n = S_WRITE;
`ifdef DECAY_ADD_EN
        if (rate == RATE_ADD) state_n = S_ADD_WAIT;
`endif
      end
`ifdef DECAY_ADD_EN
      S_ADD_WAIT: begin
        busy    = 1'b1;
        add_req = 1'b1;
        if (add_ack) state_n = S_WRITE;
      end
`endif
      S_WRITE: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        state_n = (idx == LAST_IDX) ? S_FIN : S_READ;
      end
      S_FIN:   begin done = 1'b1; state_n = S_IDLE; end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: slot index, latched rate, fetched potential, result, overrun flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx       <= '0;
      rate      <= 4'b0001;
      x         <= '0;
      result    <= '0;
      overrun_q <= 1'b0;
    end else begin
      // A start outside IDLE (FIN included) is dropped and flagged.
      if (timestep_start) overrun_q <= (state != S_IDLE);
      case (state)
        S_IDLE:  if (timestep_start) idx <= '0;
        S_READ:  rate <= rate_tab[idx];
        S_WAIT:  x <= mem_rdata;
        S_CALC:  result <= decay_shift(x, rate_shift(rate));
`ifdef DECAY_ADD_EN
        S_ADD_WAIT: if (add_ack) result <= add_result;
`endif
        S_WRITE: if (idx != LAST_IDX) idx <= idx + ADDR_W'(1);
        default: ;
      endcase
    end
  end

`ifdef DECAY_ADD_EN
  logic [31:0] add_a_q, add_b_q;
  assign add_a = add_a_q;
  assign add_b = add_b_q;

  // Adder operands x/2 and x/4 are prepared in CALC and held through ADD_WAIT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      add_a_q <= '0;
      add_b_q <= '0;
    end else if (state == S_CALC && rate == RATE_ADD) begin
      add_a_q <= decay_shift(x, 2'd1);
      add_b_q <= decay_shift(x, 2'd2);
    end
  end
`else
  logic unused_add_inputs;
  assign add_a             = '0;
  assign add_b             = '0;
  assign unused_add_inputs = ^{add_ack, add_result, RATE_ADD};
`endif

endmodule

`default_nettype wire

// File: tb/tb_decay_timestep_scheduler.sv
// ============================================================================
// tb_decay_timestep_scheduler
// Directed bench: potential RAM model with 1-cycle read latency, a fixed
// 3-cycle FP adder responder, and one task per scenario.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decay_timestep_scheduler;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        timestep_start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [3:0]  cfg_rate = '0;
  logic [4:0]  mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        add_req;
  logic [31:0] add_a, add_b;
  logic        add_ack = 1'b0;
  logic [31:0] add_result = '0;
  logic        busy, done, overrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_init [32];
  logic [31:0] wr_data  [32];
  int          wr_cnt = 0;
  logic        both_seen = 1'b0;
  int          add_cyc = 0;

  decay_timestep_scheduler #(.NUM_NEURONS(30), .ADDR_W(5)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .timestep_start(timestep_start),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_rate(cfg_rate),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .add_req(add_req), .add_a(add_a), .add_b(add_b),
    .add_ack(add_ack), .add_result(add_result),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  // RAM model: reads return the preloaded image one cycle later; writes logged.
  always @(posedge CLK) begin
    if (mem_re) mem_rdata <= ram_init[mem_addr];
    if (mem_we) begin
      wr_data[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_re && mem_we) both_seen <= 1'b1;
  end

  // Adder responder: ack in the third cycle of add_req with 8.0/2 + 8.0/4.
  always @(negedge CLK) begin
    if (add_req && !add_ack) begin
      add_cyc = add_cyc + 1;
      if (add_cyc == 3) begin
        add_ack    <= 1'b1;
        add_result <= (add_a == 32'h40800000 && add_b == 32'h40000000) ?
                      32'h40C00000 : 32'hDEADBEEF;
      end
    end else begin
      add_ack <= 1'b0;
      add_cyc = 0;
    end
  end

  task automatic fill_ram(input logic [31:0] v);
    for (int i = 0; i < 32; i++) begin
      ram_init[i] = v;
      wr_data[i]  = 32'hFFFF_FFFF;
    end
  endtask

  task automatic cfg(input logic [4:0] a, input logic [3:0] r);
    @(negedge CLK);
    cfg_we = 1'b1; cfg_addr = a; cfg_rate = r;
    @(negedge CLK);
    cfg_we = 1'b0;
  endtask

  // Start a pass; optionally pulse start again at cycle pulse_at (0 = never).
  // Returns the cycle (1 = first cycle after accept) on which done is seen.
  task automatic run_pass(input int pulse_at, output int done_cyc, output int nwr,
                          output logic first_ok, output logic [31:0] got_a,
                          output logic [31:0] got_b);
    int   cnt;
    int   start_wr;
    logic got_add;
    cnt = 0; done_cyc = -1; first_ok = 1'b0; got_add = 1'b0;
    got_a = '0; got_b = '0;
    @(negedge CLK);
    timestep_start = 1'b1;
    start_wr = wr_cnt;
    @(posedge CLK);
    #1 timestep_start = 1'b0;
    while (cnt < 400) begin
      @(negedge CLK);
      cnt++;
      timestep_start = (cnt == pulse_at);
      if (cnt == 1) first_ok = mem_re && (mem_addr == 5'd0);
      if (add_req && !got_add) begin
        got_add = 1'b1; got_a = add_a; got_b = add_b;
      end
      if (done) begin
        done_cyc = cnt;
        break;
      end
    end
    timestep_start = 1'b0;
    nwr = wr_cnt - start_wr;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if ({mem_re, mem_we, add_req, busy, done, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000000",
               {mem_re, mem_we, add_req, busy, done, overrun});
    end
    checks++;
    if ({mem_addr, mem_wdata, add_a, add_b} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h a=%h b=%h want all 0",
               mem_addr, mem_wdata, add_a, add_b);
    end
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b mem_re=%b want 0 0", busy, mem_re);
    end
  endtask

  task automatic test_basic_pass();
    int d, n; logic f; logic [31:0] a, b;
    int bad;
    fill_ram(32'h41DED852);
    run_pass(0, d, n, f, a, b);
    checks++;
    if (d !== 121) begin errors++; $display("FAIL basic_done_cycle: got %0d want 121", d); end
    checks++;
    if (n !== 30) begin errors++; $display("FAIL basic_write_count: got %0d want 30", n); end
    checks++;
    if (f !== 1'b1) begin errors++; $display("FAIL basic_first_read: got %b want 1", f); end
    bad = 0;
    for (int i = 0; i < 30; i++) if (wr_data[i] !== 32'h41DED852) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_data: %0d slots differ, slot0=%h want 41ded852", bad, wr_data[0]);
    end
    checks++;
    if (wr_data[30] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL basic_slot30_untouched: got %h want ffffffff", wr_data[30]);
    end
    @(negedge CLK);
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: overrun=%b busy=%b done=%b want 0 0 0", overrun, busy, done);
    end
  endtask

  task automatic test_rates();
    int d, n; logic f; logic [31:0] a, b;
    cfg(5'd3, 4'b0010);
    cfg(5'd4, 4'b1000);
    cfg(5'd5, 4'b0100);
    fill_ram(32'h41DED852);
    run_pass(0, d, n, f, a, b);
    checks++;
    if (wr_data[3] !== 32'h415ED852) begin
      errors++; $display("FAIL rate_div2: got %h want 415ed852", wr_data[3]);
    end
    checks++;
    if (wr_data[4] !== 32'h405ED852) begin
      errors++; $display("FAIL rate_div8: got %h want 405ed852", wr_data[4]);
    end
    checks++;
    if (wr_data[5] !== 32'h40DED852) begin
      errors++; $display("FAIL rate_div4: got %h want 40ded852", wr_data[5]);
    end
    checks++;
    if (wr_data[2] !== 32'h41DED852 || wr_data[6] !== 32'h41DED852) begin
      errors++;
      $display("FAIL rate_neighbours: got %h %h want 41ded852", wr_data[2], wr_data[6]);
    end
    checks++;
    if (d !== 121) begin errors++; $display("FAIL rate_done_cycle: got %0d want 121", d); end
  endtask

  task automatic test_boundaries();
    int d, n; logic f; logic [31:0] a, b;
    logic [31:0] exp_add; int exp_d;
    cfg(5'd6, 4'b1000);
    cfg(5'd7, 4'b1000);
    cfg(5'd8, 4'b1000);
    cfg(5'd9, 4'b1000);
    cfg(5'd10, 4'b1000);
    cfg(5'd11, 4'b0011);
    cfg(5'd12, 4'b0010);
    fill_ram(32'h41DED852);
    ram_init[6]  = 32'h01000000;
    ram_init[7]  = 32'h81000000;
    ram_init[8]  = 32'h7F800000;
    ram_init[9]  = 32'h00400000;
    ram_init[10] = 32'h02000000;
    ram_init[11] = 32'h41000000;
    ram_init[12] = 32'h7FC00001;
`ifdef DECAY_ADD_EN
    exp_add = 32'h40C00000; exp_d = 124;
`else
    exp_add = 32'h41000000; exp_d = 121;
`endif
    run_pass(0, d, n, f, a, b);
    checks++;
    if (wr_data[6] !== 32'h00000000) begin
      errors++; $display("FAIL flush_pos_zero: got %h want 00000000", wr_data[6]);
    end
    checks++;
    if (wr_data[7] !== 32'h80000000) begin
      errors++; $display("FAIL flush_neg_zero: got %h want 80000000", wr_data[7]);
    end
    checks++;
    if (wr_data[8] !== 32'h7F800000) begin
      errors++; $display("FAIL inf_passthru: got %h want 7f800000", wr_data[8]);
    end
    checks++;
    if (wr_data[9] !== 32'h00400000) begin
      errors++; $display("FAIL denorm_passthru: got %h want 00400000", wr_data[9]);
    end
    checks++;
    if (wr_data[10] !== 32'h00800000) begin
      errors++; $display("FAIL min_normal: got %h want 00800000", wr_data[10]);
    end
    checks++;
    if (wr_data[12] !== 32'h7FC00001) begin
      errors++; $display("FAIL nan_passthru: got %h want 7fc00001", wr_data[12]);
    end
    checks++;
    if (wr_data[11] !== exp_add) begin
      errors++; $display("FAIL add_rate_result: got %h want %h", wr_data[11], exp_add);
    end
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL add_pass_cycles: got %0d want %0d", d, exp_d);
    end
`ifdef DECAY_ADD_EN
    checks++;
    if (a !== 32'h40800000 || b !== 32'h40000000) begin
      errors++; $display("FAIL add_operands: got %h %h want 40800000 40000000", a, b);
    end
`else
    checks++;
    if (a !== 32'h0 || b !== 32'h0) begin
      errors++; $display("FAIL add_tied_off: got %h %h want 0 0", a, b);
    end
`endif
    cfg(5'd11, 4'b0001);
  endtask

  task automatic test_overrun();
    int d, n; logic f; logic [31:0] a, b;
    fill_ram(32'h41DED852);
    run_pass(50, d, n, f, a, b);
    checks++;
    if (d !== 121 || n !== 30) begin
      errors++; $display("FAIL overrun_pass_len: got %0d/%0d want 121/30", d, n);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b want 1", overrun);
    end
    // Start coinciding with done (FIN) is dropped and flagged.
    timestep_start = 1'b1;
    @(posedge CLK);
    #1 timestep_start = 1'b0;
    @(negedge CLK);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL start_at_fin: overrun=%b busy=%b mem_re=%b want 1 0 0", overrun, busy, mem_re);
    end
    run_pass(0, d, n, f, a, b);
    checks++;
    if (overrun !== 1'b0 || d !== 121) begin
      errors++; $display("FAIL overrun_clear: overrun=%b done=%0d want 0 121", overrun, d);
    end
  endtask

  task automatic test_reset_mid_pass();
    int d, n; logic f; logic [31:0] a, b;
    logic found; logic done_seen;
    found = 1'b0; done_seen = 1'b0;
    fill_ram(32'h41DED852);
    @(negedge CLK);
    timestep_start = 1'b1;
    @(posedge CLK);
    #1 timestep_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (mem_we && mem_addr == 5'd10) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL slot10_write_seen: got 0 want 1"); end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 5'd0) begin
      errors++;
      $display("FAIL async_abort: we=%b busy=%b done=%b addr=%0d want 0 0 0 0",
               mem_we, busy, done, mem_addr);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done || busy) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin errors++; $display("FAIL no_done_after_abort: got 1 want 0"); end
    run_pass(0, d, n, f, a, b);
    checks++;
    if (f !== 1'b1 || d !== 121 || n !== 30) begin
      errors++;
      $display("FAIL restart_after_abort: first=%b done=%0d writes=%0d want 1 121 30", f, d, n);
    end
  endtask

  task automatic test_strobe_exclusive();
    checks++;
    if (both_seen !== 1'b0) begin
      errors++; $display("FAIL re_we_exclusive: got %b want 0", both_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_rates();
    test_boundaries();
    test_overrun();
    test_reset_mid_pass();
    test_strobe_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
